// File: rtl/modexp_pkg.sv
// Shared constants and FSM encoding for the modexp datapath blocks.
package modexp_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 8;
  localparam int NN_W   = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_LOOP_RD = 3'd2,
    ST_LOOP_WR = 3'd3,
    ST_SELECT  = 3'd4,
    ST_COPY_RD = 3'd5,
    ST_COPY_WR = 3'd6,
    ST_DONE    = 3'd7
  } residue_state_t;

endpackage

// File: rtl/residue_word_alu.sv
// One word of the doubling step: shifted word s = 2*x (with carry chain) and
// trial difference d = s - M - borrow.
module residue_word_alu
  import modexp_pkg::*;
(
  input  logic [WORD_W-1:0] x_word,
  input  logic [WORD_W-1:0] m_word,
  input  logic              shift_carry_in,
  input  logic              borrow_in,
  output logic [WORD_W-1:0] s_word,
  output logic [WORD_W-1:0] d_word,
  output logic              shift_carry_out,
  output logic              borrow_out
);

  logic [WORD_W:0] diff;

  assign s_word          = {x_word[WORD_W-2:0], shift_carry_in};
  assign shift_carry_out = x_word[WORD_W-1];
  // A negative 33-bit result wraps and sets the top bit, which is the borrow.
  assign diff            = {1'b0, s_word} - {1'b0, m_word} - {{WORD_W{1'b0}}, borrow_in};
  assign d_word          = diff[WORD_W-1:0];
  assign borrow_out      = diff[WORD_W];

endmodule

// File: rtl/residue.sv
// Computes 2^nn mod M word-serially into the result memory by repeated
// doubling with conditional subtraction; temp memory holds the trial difference.
module residue
  import modexp_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                calculate,
  output logic                ready,
  input  logic [ADDR_W-1:0]   length,
  input  logic [NN_W-1:0]     nn,
  output logic [ADDR_W-1:0]   opm_addr,
  input  logic [WORD_W-1:0]   opm_data,
  output logic [ADDR_W-1:0]   temp_addr,
  input  logic [WORD_W-1:0]   temp_rd_data,
  output logic [WORD_W-1:0]   temp_wr_data,
  output logic                temp_we,
  output logic [ADDR_W-1:0]   result_addr,
  input  logic [WORD_W-1:0]   result_rd_data,
  output logic [WORD_W-1:0]   result_wr_data,
  output logic                result_we,
  output logic [2:0]          dbg_state
);

  // calculate/ready: a start is accepted on any edge where ready=1 and
  // calculate=1; ready stays low until the result memory holds the answer.

  residue_state_t    state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [ADDR_W-1:0] len_r, len_n;
  logic [NN_W-1:0]   iter, iter_n;
  logic              sc, sc_n;
  logic              br, br_n;
  logic              ready_n;
  logic              result_we_n, temp_we_n;

  logic [WORD_W-1:0] alu_s, alu_d;
  logic              alu_sc, alu_br;

  residue_word_alu u_alu (
    .x_word          (result_rd_data),
    .m_word          (opm_data),
    .shift_carry_in  (sc),
    .borrow_in       (br),
    .s_word          (alu_s),
    .d_word          (alu_d),
    .shift_carry_out (alu_sc),
    .borrow_out      (alu_br)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      len_r     <= '0;
      iter      <= '0;
      sc        <= 1'b0;
      br        <= 1'b0;
      ready     <= 1'b1;
      result_we <= 1'b0;
      temp_we   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      len_r     <= len_n;
      iter      <= iter_n;
      sc        <= sc_n;
      br        <= br_n;
      ready     <= ready_n;
      result_we <= result_we_n;
      temp_we   <= temp_we_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    len_n       = len_r;
    iter_n      = iter;
    sc_n        = sc;
    br_n        = br;
    ready_n     = ready;
    result_we_n = 1'b0;
    temp_we_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (calculate) begin
          len_n   = length;
          iter_n  = nn;
          ready_n = 1'b0;
          if (length == '0) begin
            state_n = ST_DONE;
          end else begin
            state_n     = ST_INIT;
            idx_n       = length - 8'd1;
            result_we_n = 1'b1;
          end
        end
      end
      ST_INIT: begin
        if (idx == '0) begin
          if (iter == '0) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_LOOP_RD;
            idx_n   = len_r - 8'd1;
            sc_n    = 1'b0;
            br_n    = 1'b0;
          end
        end else begin
          idx_n       = idx - 8'd1;
          result_we_n = 1'b1;
        end
      end
      ST_LOOP_RD: begin
        state_n     = ST_LOOP_WR;
        result_we_n = 1'b1;
        temp_we_n   = 1'b1;
      end
      ST_LOOP_WR: begin
        sc_n = alu_sc;
        br_n = alu_br;
        if (idx == '0) begin
          state_n = ST_SELECT;
        end else begin
          state_n = ST_LOOP_RD;
          idx_n   = idx - 8'd1;
        end
      end
      ST_SELECT: begin
        // 2x >= M when the doubling overflowed the operand or did not borrow.
        if (sc || !br) begin
          state_n = ST_COPY_RD;
          idx_n   = len_r - 8'd1;
        end else begin
          iter_n = iter - 15'd1;
          if (iter == 15'd1) begin
            state_n = ST_DONE;
            idx_n   = '0;
          end else begin
            state_n = ST_LOOP_RD;
            idx_n   = len_r - 8'd1;
            sc_n    = 1'b0;
            br_n    = 1'b0;
          end
        end
      end
      ST_COPY_RD: begin
        state_n     = ST_COPY_WR;
        result_we_n = 1'b1;
      end
      ST_COPY_WR: begin
        if (idx == '0) begin
          iter_n = iter - 15'd1;
          if (iter == 15'd1) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_LOOP_RD;
            idx_n   = len_r - 8'd1;
            sc_n    = 1'b0;
            br_n    = 1'b0;
          end
        end else begin
          state_n = ST_COPY_RD;
          idx_n   = idx - 8'd1;
        end
      end
      ST_DONE: begin
        ready_n = 1'b1;
        state_n = ST_IDLE;
        idx_n   = '0;
      end
      default: begin
        state_n = ST_IDLE;
        ready_n = 1'b1;
        idx_n   = '0;
      end
    endcase
  end

  // Write data is a mux of the current word, qualified by the registered enables.
  always_comb begin
    result_wr_data = '0;
    temp_wr_data   = '0;
    if (result_we) begin
      case (state)
        ST_INIT:    result_wr_data = (idx == len_r - 8'd1) ? 32'd1 : 32'd0;
        ST_LOOP_WR: result_wr_data = alu_s;
        ST_COPY_WR: result_wr_data = temp_rd_data;
        default:    result_wr_data = '0;
      endcase
    end
    if (temp_we) begin
      temp_wr_data = alu_d;
    end
  end

  assign opm_addr    = idx;
  assign temp_addr   = idx;
  assign result_addr = idx;
  assign dbg_state   = state;

endmodule

// File: tb/tb_residue.sv
// Bench for residue: memory models around the DUT, directed spec cases, busy and
// reset scenarios, and randomized runs checked against an arithmetic model.
module tb_residue;
  import modexp_pkg::*;

  logic        tb_clk = 1'b0;
  logic        reset;
  logic        calculate;
  logic        ready;
  logic [7:0]  length;
  logic [14:0] nn;
  logic [7:0]  opm_addr, temp_addr, result_addr;
  logic [31:0] opm_data, temp_rd_data, temp_wr_data, result_rd_data, result_wr_data;
  logic        temp_we, result_we;
  logic [2:0]  dbg_state;

  logic [31:0] opm_mem    [256];
  logic [31:0] temp_mem   [256];
  logic [31:0] result_mem [256];

  int checks = 0;
  int passes = 0;

  always #5 tb_clk = ~tb_clk;

  residue dut (
    .clk            (tb_clk),
    .reset          (reset),
    .calculate      (calculate),
    .ready          (ready),
    .length         (length),
    .nn             (nn),
    .opm_addr       (opm_addr),
    .opm_data       (opm_data),
    .temp_addr      (temp_addr),
    .temp_rd_data   (temp_rd_data),
    .temp_wr_data   (temp_wr_data),
    .temp_we        (temp_we),
    .result_addr    (result_addr),
    .result_rd_data (result_rd_data),
    .result_wr_data (result_wr_data),
    .result_we      (result_we),
    .dbg_state      (dbg_state)
  );

  // Synchronous-read memories with one cycle of latency, read-before-write.
  always @(posedge tb_clk) begin
    opm_data       <= opm_mem[opm_addr];
    temp_rd_data   <= temp_mem[temp_addr];
    result_rd_data <= result_mem[result_addr];
    if (temp_we) temp_mem[temp_addr] <= temp_wr_data;
    if (result_we) result_mem[result_addr] <= result_wr_data;
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: 2^nn mod M as plain big-integer arithmetic; s counts reductions.
  task automatic model(input logic [127:0] m, input int nnv,
                       output logic [127:0] r, output int s);
    logic [128:0] x;
    x = 129'd1;
    s = 0;
    for (int k = 0; k < nnv; k++) begin
      x = x << 1;
      if (x >= {1'b0, m}) begin
        x = x - {1'b0, m};
        s++;
      end
    end
    r = x[127:0];
  endtask

  task automatic load_m(input int len, input logic [127:0] m);
    for (int i = 0; i < len; i++) opm_mem[i] = m[32*(len-1-i) +: 32];
  endtask

  task automatic run(input int len, input int nnv, input bit poke,
                     output int cycles, output int writes);
    @(negedge tb_clk);
    length    = 8'(len);
    nn        = 15'(nnv);
    calculate = 1'b1;
    @(posedge tb_clk);
    @(negedge tb_clk);
    calculate = 1'b0;
    cycles    = 1;
    writes    = 0;
    while (ready !== 1'b1 && cycles < 20000) begin
      if (result_we === 1'b1) writes++;
      if (poke) begin
        calculate = 1'($urandom_range(0, 1));
        length    = 8'($urandom);
        nn        = 15'($urandom);
      end
      @(posedge tb_clk);
      cycles++;
      @(negedge tb_clk);
    end
    calculate = 1'b0;
    check32("ready_returned", {31'd0, ready}, 32'd1);
  endtask

  task automatic run_case(input string tag, input int len, input logic [127:0] m,
                          input int nnv, input bit poke,
                          input bit has_spec, input logic [127:0] spec_exp);
    logic [127:0] r;
    int s, cycles, writes;
    load_m(len, m);
    model(m, nnv, r, s);
    run(len, nnv, poke, cycles, writes);
    check32({tag, "_cycles"}, 32'(cycles), 32'(len + nnv*(2*len+1) + 2*len*s + 2));
    check32({tag, "_writes"}, 32'(writes), 32'(len + nnv*len + s*len));
    for (int i = 0; i < len; i++) begin
      check32({tag, "_word"}, result_mem[i], r[32*(len-1-i) +: 32]);
      if (has_spec) check32({tag, "_spec"}, result_mem[i], spec_exp[32*(len-1-i) +: 32]);
    end
  endtask

  initial begin
    logic [127:0] m;
    int len, nnv, sel, cycles, writes, waited;

    reset     = 1'b1;
    calculate = 1'b0;
    length    = 8'd0;
    nn        = 15'd0;
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    check32("rst_ready", {31'd0, ready}, 32'd1);
    check32("rst_result_we", {31'd0, result_we}, 32'd0);
    check32("rst_temp_we", {31'd0, temp_we}, 32'd0);
    check32("rst_addr", {8'd0, opm_addr, temp_addr, result_addr}, 32'd0);
    check32("rst_wdata", result_wr_data | temp_wr_data, 32'd0);
    reset = 1'b0;

    run_case("m13_nn32", 1, 128'h13, 32, 1'b0, 1'b1, 128'h6);
    run_case("m13_nn64", 1, 128'h13, 64, 1'b0, 1'b1, 128'h11);
    run_case("m2w_nn32", 2, {64'd0, 32'h1, 32'h1}, 32, 1'b0, 1'b1, {64'd0, 32'h1, 32'h0});
    run_case("m2w_nn128", 2, {64'd0, 32'h1, 32'h1}, 128, 1'b0, 1'b1, {64'd0, 32'h0, 32'h1});
    run_case("mff_nn64", 1, 128'hFFFF_FFFF, 64, 1'b0, 1'b1, 128'h1);
    run_case("mff_nn0", 1, 128'hFFFF_FFFF, 0, 1'b0, 1'b1, 128'h1);
    run_case("busy_poke", 1, 128'h13, 64, 1'b1, 1'b1, 128'h11);

    run(0, 50, 1'b0, cycles, writes);
    check32("len0_writes", 32'(writes), 32'd0);
    check32("len0_fast", {31'd0, cycles <= 3}, 32'd1);

    // Reset while a doubling pass is writing.
    load_m(1, 128'h13);
    @(negedge tb_clk);
    length    = 8'd1;
    nn        = 15'd64;
    calculate = 1'b1;
    @(negedge tb_clk);
    calculate = 1'b0;
    waited    = 0;
    while (dbg_state !== 3'(ST_LOOP_WR) && waited < 50) begin
      @(negedge tb_clk);
      waited++;
    end
    check32("rst_found_loop_wr", {29'd0, dbg_state}, {29'd0, 3'(ST_LOOP_WR)});
    reset = 1'b1;
    @(posedge tb_clk);
    @(negedge tb_clk);
    check32("midrst_ready", {31'd0, ready}, 32'd1);
    check32("midrst_we", {30'd0, result_we, temp_we}, 32'd0);
    check32("midrst_addr", {8'd0, opm_addr, temp_addr, result_addr}, 32'd0);
    check32("midrst_state", {29'd0, dbg_state}, {29'd0, 3'(ST_IDLE)});
    reset = 1'b0;
    run_case("after_rst_m11", 1, 128'h11, 64, 1'b0, 1'b1, 128'h1);

    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 4);
      m   = {$urandom, $urandom, $urandom, $urandom};
      if (len < 4) m = m & ((128'd1 << (32*len)) - 128'd1);
      if (m <= 128'd1) m = 128'd3;
      sel = $urandom_range(0, 2);
      nnv = (sel == 0) ? 32*len : (sel == 1) ? 64*len : $urandom_range(1, 100);
      run_case("rand", len, m, nnv, 1'($urandom_range(0, 1)), 1'b0, 128'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
